// File: rtl/min_func_sweeper.sv
// Sweeps the 4-in/2-out minimized function unit over a code range [lo, hi],
// streaming each result and counting o1/o0 hits. Optional hold input under MIN_SWEEP_HOLD_EN.

module min_func_unit (
  input  logic [3:0] i,
  output logic       o1,
  output logic       o0
);

  assign o1 = ~i[0];
  assign o0 = i[0] & ~(i[1] & i[3]);

endmodule

module min_func_sweeper (
  input  logic       clk,
  input  logic       rst_b,
`ifdef MIN_SWEEP_HOLD_EN
  input  logic       hold,
`endif
  input  logic       start,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  output logic       busy,
  output logic       valid,
  output logic [3:0] code,
  output logic       o1,
  output logic       o0,
  output logic [4:0] cnt1,
  output logic [4:0] cnt0,
  output logic       done,
  output logic       err
);

  localparam int CODE_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q,  code_d;
  logic [CODE_W-1:0]   hi_q,    hi_d;
  logic [CNT_W-1:0]    cnt1_q,  cnt1_d;
  logic [CNT_W-1:0]    cnt0_q,  cnt0_d;
  logic                err_q,   err_d;
  logic                hold_w;
  logic                fu_o1, fu_o0;

`ifdef MIN_SWEEP_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  min_func_unit u_fu (
    .i  (code_q),
    .o1 (fu_o1),
    .o0 (fu_o0)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    code_d  = code_q;
    hi_d    = hi_q;
    cnt1_d  = cnt1_q;
    cnt0_d  = cnt0_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt1_d = '0;
          cnt0_d = '0;
          if (lo <= hi) begin
            code_d  = lo;
            hi_d    = hi;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!hold_w) begin
          cnt1_d = cnt1_q + CNT_W'(fu_o1);
          cnt0_d = cnt0_q + CNT_W'(fu_o0);
          // Ending on the compare keeps hi=15 from wrapping code back to 0.
          if (code_q == hi_q) state_d = S_DONE;
          else                code_d  = code_q + CODE_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_b) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      hi_q    <= '0;
      cnt1_q  <= '0;
      cnt0_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hi_q    <= hi_d;
      cnt1_q  <= cnt1_d;
      cnt0_q  <= cnt0_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = (state_q == S_RUN) && !hold_w;
  assign done  = (state_q == S_DONE);
  assign code  = code_q;
  assign o1    = fu_o1;
  assign o0    = fu_o0;
  assign cnt1  = cnt1_q;
  assign cnt0  = cnt0_q;
  assign err   = err_q;

endmodule
